// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and types for the RAM_B two-port arbiter.
// Port indices, default geometry and port-select helpers.
package ram_port_arbiter_pkg;

  localparam int unsigned RD_PORT       = 0;
  localparam int unsigned WR_PORT       = 1;
  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_BURST = 4;

  typedef enum logic {
    PORT_RD = 1'b0,
    PORT_WR = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_RD) ? PORT_WR : PORT_RD;
  endfunction

  function automatic logic [1:0] port_onehot(input port_e p);
    return (p == PORT_WR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the RAM_B arbiter: beat handshake plus read return.
// master = datapath requesters, slave = arbiter.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr;
  logic [2*DATA_W-1:0] wdata;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                busy;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, busy
  );
endinterface

// File: rtl/ram_port_arbiter_pick.sv
// Combinational 2-way picker: request vector, burst owner/count and
// last winner in, one-hot grant and idle-tie flag out.
module ram_arb_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = DEF_MAX_BURST,
  parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic [1:0]       req,
  input  port_e            owner,
  input  logic [CNT_W-1:0] count,
  input  port_e            last_winner,
  input  logic             beat_q,
  output logic [1:0]       gnt,
  output logic             tie
);

  logic own_req;
  logic oth_req;

  assign own_req = (owner == PORT_WR) ? req[WR_PORT] : req[RD_PORT];
  assign oth_req = (owner == PORT_WR) ? req[RD_PORT] : req[WR_PORT];

  always_comb begin
    gnt = '0;
    tie = ~beat_q & req[RD_PORT] & req[WR_PORT];
    if (tie) begin
      gnt = port_onehot(other_port(last_winner));
    end else if (own_req && ((count < CNT_W'(MAX_BURST)) || !oth_req)) begin
      gnt = port_onehot(owner);
    end else if (oth_req) begin
      gnt = port_onehot(other_port(owner));
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates RAM_B between the reader (port 0) and writer (port 1), registers
// the RAM command and routes read data back. RAM_ARB_RR_EN: round-robin idle tie.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 clk,
  input  logic                 RSTN,
  ram_port_arbiter_if.slave    bus,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_din,
  input  logic [DATA_W-1:0]    ram_dout
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  port_e             owner_q;
  port_e             last_winner;
  port_e             win;
  port_e             cmd_port_q;
  logic [CNT_W-1:0]  count_q;
  logic              beat_q;
  logic              beat;
  logic              tie;
  logic [1:0]        gnt_pick;
  logic [1:0]        gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              cmd_valid_q;
  logic              cmd_rd_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  ram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .req         (bus.req),
    .owner       (owner_q),
    .count       (count_q),
    .last_winner (last_winner),
    .beat_q      (beat_q),
    .gnt         (gnt_pick),
    .tie         (tie)
  );

  // Grant is combinational, so it is gated by reset to read 0 while RSTN is low.
  assign gnt  = gnt_pick & {2{RSTN}};
  assign beat = |gnt;
  assign win  = gnt[WR_PORT] ? PORT_WR : PORT_RD;

  assign sel_we    = (win == PORT_WR) ? bus.we[WR_PORT] : bus.we[RD_PORT];
  assign sel_addr  = (win == PORT_WR) ? bus.addr[2*ADDR_W-1:ADDR_W]  : bus.addr[ADDR_W-1:0];
  assign sel_wdata = (win == PORT_WR) ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];

`ifdef RAM_ARB_RR_EN
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      last_winner <= PORT_WR;
    end else if (beat) begin
      last_winner <= win;
    end
  end
`else
  assign last_winner = PORT_WR;
`endif

  // An idle-tie win starts a fresh burst even when the previous owner wins it.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      owner_q <= PORT_RD;
      count_q <= '0;
      beat_q  <= 1'b0;
    end else begin
      beat_q <= beat;
      if (beat) begin
        owner_q <= win;
        if (tie || (win != owner_q)) begin
          count_q <= CNT_W'(1);
        end else if (count_q != CNT_W'(MAX_BURST)) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cmd_valid_q <= 1'b0;
      cmd_rd_q    <= 1'b0;
      cmd_port_q  <= PORT_RD;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      cmd_valid_q <= beat;
      cmd_rd_q    <= beat & ~sel_we;
      cmd_port_q  <= win;
      ram_we      <= beat & sel_we;
      if (beat) begin
        ram_addr <= sel_addr;
        ram_din  <= sel_wdata;
      end
      rvalid_q <= '0;
      if (cmd_rd_q) begin
        rvalid_q <= port_onehot(cmd_port_q);
        rdata_q  <= ram_dout;
      end
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = cmd_valid_q | (|rvalid_q);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: grant table plus read-return scoreboard.
// Honours RAM_ARB_RR_EN for the expected idle-tie winners.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [1:0]    g;
  } row_t;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    int            cyc;
  } sb_t;

  logic          clk = 1'b0;
  logic          RSTN;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem    [1024];
  logic [DW-1:0] shadow [1024];

  row_t rows[$];
  sb_t  sb[$];
  sb_t  e_mon;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   we_cnt = 0;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  ram_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (4)
  ) dut (
    .clk      (clk),
    .RSTN     (RSTN),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM_B: clocked on ~clk, read data ignored on write cycles
  always @(negedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout      <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [1:0] r, input logic [1:0] w, input int a0,
                              input int a1, input logic [DW-1:0] d, input logic [1:0] g);
    row_t e;
    e.req = r; e.we = w; e.a0 = a0[AW-1:0]; e.a1 = a1[AW-1:0]; e.d1 = d; e.g = g;
    rows.push_back(e);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(2'b00, 2'b00, 0, 0, 32'h0, 2'b00);
  endfunction

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, 32'h0};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},      64'(bus.gnt),    64'(0));
    chk({tag, "_rvalid"},   64'(bus.rvalid), 64'(0));
    chk({tag, "_rdata"},    64'(bus.rdata),  64'(0));
    chk({tag, "_ram_we"},   64'(ram_we),     64'(0));
    chk({tag, "_ram_addr"}, 64'(ram_addr),   64'(0));
    chk({tag, "_ram_din"},  64'(ram_din),    64'(0));
    chk({tag, "_busy"},     64'(bus.busy),   64'(0));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk({tag, "_pending_reads"}, 64'(sb.size()), 64'(0));
  endtask

  // Scoreboard: accepted reads are pushed with the model's data, popped on rvalid
  always @(negedge clk) begin
    if (!RSTN) begin
      sb.delete();
    end else begin
      if (bus.rvalid != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected actual=%b required=00", bus.rvalid);
        end else begin
          e_mon = sb.pop_front();
          chk("rvalid_port", 64'(bus.rvalid), 64'(e_mon.port ? 2'b10 : 2'b01));
          chk("rdata",       64'(bus.rdata),  64'(e_mon.data));
          chk("rd_latency",  64'(cyc),        64'(e_mon.cyc + 2));
        end
      end
      if (ram_we) we_cnt++;
      for (int p = 0; p < 2; p++) begin
        if (bus.req[p] && bus.gnt[p]) begin
          if (bus.we[p]) begin
            shadow[bus.addr[p*AW +: AW]] = bus.wdata[p*DW +: DW];
          end else begin
            e_mon.port = (p == 1);
            e_mon.data = shadow[bus.addr[p*AW +: AW]];
            e_mon.cyc  = cyc;
            sb.push_back(e_mon);
          end
        end
      end
      cyc++;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'hC0DE_0000 + i;
      shadow[i] = 32'hC0DE_0000 + i;
    end
    mem[5]    = 32'hDEADBEEF;
    shadow[5] = 32'hDEADBEEF;

    // single read of addr 5
    add(2'b01, 2'b00, 5, 0, 32'h0, 2'b01);
    idle(3);
    // write addr 3 on port 1, read it back on port 0 next cycle
    add(2'b10, 2'b10, 0, 3, 32'h12345678, 2'b10);
    add(2'b01, 2'b00, 3, 0, 32'h0, 2'b01);
    idle(3);
    // port 1 beat first so both builds start the burst test on port 0
    add(2'b10, 2'b00, 0, 9, 32'h0, 2'b10);
    idle(1);
    for (int k = 0; k < 9; k++)
      add(2'b11, 2'b00, 16 + k, 32 + k, 32'h0, (k < 4 || k == 8) ? 2'b01 : 2'b10);
    idle(3);
    // lone reader for 10 cycles past saturation, then writer joins
    for (int k = 0; k < 10; k++) add(2'b01, 2'b00, 48 + k, 0, 32'h0, 2'b01);
    add(2'b11, 2'b00, 60, 61, 32'h0, 2'b10);
    idle(3);
    // repeated single-beat idle ties
    for (int k = 0; k < 4; k++) begin
      add(2'b11, 2'b00, 70 + k, 80 + k, 32'h0, (RR && (k % 2 == 1)) ? 2'b10 : 2'b01);
      idle(1);
    end

    RSTN = 1'b0;
    drive(2'b11, 2'b00, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #1 RSTN = 1'b1;
    drive(2'b00, 2'b00, '0, '0, '0);

    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk);
      #1 drive(rows[i].req, rows[i].we, rows[i].a0, rows[i].a1, rows[i].d1);
      @(negedge clk);
      if (bus.gnt !== rows[i].g) begin
        $display("FAIL gnt_row%0d actual=%b required=%b", i, bus.gnt, rows[i].g);
        errors++;
      end
      checks++;
    end
    @(posedge clk);
    #1 drive(2'b00, 2'b00, '0, '0, '0);
    drain("table");
    chk("ram_we_pulses", 64'(we_cnt), 64'(1));

    // reset the cycle after a read grant
    @(posedge clk);
    #1 drive(2'b01, 2'b00, 10'd7, '0, '0);
    @(negedge clk);
    chk("rst_seq_gnt", 64'(bus.gnt), 64'(2'b01));
    @(posedge clk);
    #1 drive(2'b00, 2'b00, '0, '0, '0);
    RSTN = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 RSTN = 1'b1;
    repeat (4) @(posedge clk);
    #1 drive(2'b11, 2'b00, 10'd11, 10'd12, '0);
    @(negedge clk);
    chk("post_rst_tie_gnt", 64'(bus.gnt), 64'(2'b01));
    @(posedge clk);
    #1 drive(2'b00, 2'b00, '0, '0, '0);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
